// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives a req/ack data-memory handshake from the EX/MEM
// register, stalls upstream while an access is outstanding, and owns MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_in,
  input  logic [1:0]  m_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_wb;
  logic [4:0]       lat_rd;
  logic             is_mem, misalign, start, done, abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    is_mem    = |m_in;
    misalign  = is_mem && (|alu_result[1:0]);
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    stall     = 1'b0;
    nxt_state = state;
    case (state)
      IDLE: begin
        if (is_mem && !misalign) begin
          start     = 1'b1;
          stall     = 1'b1;
          nxt_state = ACCESS;
        end
      end
      ACCESS: begin
        // ack takes priority over a timeout landing on the same cycle
        if (mem_ack) begin
          done      = 1'b1;
          nxt_state = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          nxt_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // mem_addr doubles as the latched alu_result of the outstanding op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cnt            <= '0;
      lat_wb         <= '0;
      lat_rd         <= '0;
      wb_out         <= '0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
      err            <= 1'b0;
    end else begin
      err            <= 1'b0;
      wb_out         <= '0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
      if (state == IDLE) begin
        if (!is_mem) begin
          wb_out         <= wb_in;
          alu_result_out <= alu_result;
          write_reg_out  <= write_reg;
        end else if (misalign) begin
          err <= 1'b1;
        end else if (start) begin
          mem_req   <= 1'b1;
          mem_we    <= m_in[1];
          mem_addr  <= alu_result;
          mem_wdata <= write_data;
          cnt       <= '0;
          lat_wb    <= wb_in;
          lat_rd    <= write_reg;
          err       <= &m_in;
        end
      end else begin
        if (done) begin
          mem_req        <= 1'b0;
          wb_out         <= lat_wb;
          read_data_out  <= mem_we ? 32'd0 : mem_rdata;
          alu_result_out <= mem_addr;
          write_reg_out  <= lat_rd;
        end else if (abort) begin
          mem_req <= 1'b0;
          err     <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
